// File: rtl/rf_pkg.sv
// Shared sizes and types for the MIPS-style register file.
package rf_pkg;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam int NUM_REGS = 32;
  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/rf_read_port.sv
// Combinational read selector: array lookup, hard-wired zero register and,
// when RF_BYPASS_EN is defined, write-through forwarding of the pending write.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0]                       addr,
  input  logic [(2**ADDR_WIDTH)-1:1][DATA_WIDTH-1:0]  regs,
`ifdef RF_BYPASS_EN
  input  logic                                        wrValid,
  input  logic [ADDR_WIDTH-1:0]                       wrAddr,
  input  logic [DATA_WIDTH-1:0]                       wrData,
`endif
  output logic [DATA_WIDTH-1:0]                       data
);

  always_comb begin
    data = '0;
    if (addr != '0) begin
      data = regs[addr];
    end
`ifdef RF_BYPASS_EN
    // wrValid already excludes reset and register 0
    if (wrValid && (addr == wrAddr)) begin
      data = wrData;
    end
`endif
  end

endmodule

// File: rtl/register_file.sv
// 32x32 register file, two combinational read ports, one write port committing
// on the falling edge of Clk. Optional write-through bypass: RF_BYPASS_EN.
module register_file
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  RegWre,
  input  logic [ADDR_WIDTH-1:0] rs,
  input  logic [ADDR_WIDTH-1:0] rt,
  input  logic [ADDR_WIDTH-1:0] WriteReg,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2
);

  localparam int REG_COUNT = 2**ADDR_WIDTH;

  // Register 0 has no storage; the read ports return 0 for it.
  logic [REG_COUNT-1:1][DATA_WIDTH-1:0] regFile;
  logic                                 writeValid;

  assign writeValid = RegWre && (WriteReg != '0);

  // Falling-edge commit lets ID read the WB value in the second half-cycle.
  always_ff @(negedge Clk) begin
    if (Reset) begin
      regFile <= '0;
    end else if (writeValid) begin
      regFile[WriteReg] <= WriteData;
    end
  end

`ifdef RF_BYPASS_EN
  logic bypassValid;
  assign bypassValid = writeValid && !Reset;
`endif

  rf_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) readPort1 (
    .addr   (rs),
    .regs   (regFile),
`ifdef RF_BYPASS_EN
    .wrValid(bypassValid),
    .wrAddr (WriteReg),
    .wrData (WriteData),
`endif
    .data   (ReadData1)
  );

  rf_read_port #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) readPort2 (
    .addr   (rt),
    .regs   (regFile),
`ifdef RF_BYPASS_EN
    .wrValid(bypassValid),
    .wrAddr (WriteReg),
    .wrData (WriteData),
`endif
    .data   (ReadData2)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed cases then random traffic
// against an array reference model. Honours RF_BYPASS_EN when defined.
module tb_register_file;
  import rf_pkg::*;

  logic      Clk = 1'b0;
  logic      Reset = 1'b0;
  logic      RegWre = 1'b0;
  reg_addr_t rs = '0;
  reg_addr_t rt = '0;
  reg_addr_t WriteReg = '0;
  word_t     WriteData = '0;
  word_t     ReadData1;
  word_t     ReadData2;

  int checks = 0;
  int errors = 0;

  word_t model [NUM_REGS];
  bit    modelKnown = 1'b0;

  always #5 Clk = ~Clk;

  register_file dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .RegWre   (RegWre),
    .rs       (rs),
    .rt       (rt),
    .WriteReg (WriteReg),
    .WriteData(WriteData),
    .ReadData1(ReadData1),
    .ReadData2(ReadData2)
  );

  task automatic chk(input string tag, input word_t got, input word_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected read value; before the edge the pending write is visible only with bypass.
  function automatic word_t expRead(input reg_addr_t a, input bit preEdge);
    if (a == 5'd0) return '0;
`ifdef RF_BYPASS_EN
    if (preEdge && RegWre && !Reset && WriteReg != 5'd0 && a == WriteReg) return WriteData;
`else
    if (preEdge && 1'b0) return WriteData;
`endif
    return model[a];
  endfunction

  task automatic cycle(input bit rst, input bit we, input reg_addr_t wa, input word_t wd,
                       input reg_addr_t a1, input reg_addr_t a2);
    @(posedge Clk);
    Reset = rst; RegWre = we; WriteReg = wa; WriteData = wd; rs = a1; rt = a2;
    #1;
    if (modelKnown) begin
      chk("pre_rd1", ReadData1, expRead(a1, 1'b1));
      chk("pre_rd2", ReadData2, expRead(a2, 1'b1));
    end
    @(negedge Clk);
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
      modelKnown = 1'b1;
    end else if (we && wa != 5'd0) begin
      model[wa] = wd;
    end
    #1;
    if (modelKnown) begin
      chk("post_rd1", ReadData1, expRead(a1, 1'b0));
      chk("post_rd2", ReadData2, expRead(a2, 1'b0));
    end
  endtask

  initial begin
    // Reset, then sweep every address on both ports.
    cycle(1'b1, 1'b0, 5'd0, '0, 5'd0, 5'd0);
    Reset = 1'b0;
    for (int a = 0; a < NUM_REGS; a++) begin
      rs = reg_addr_t'(a);
      rt = reg_addr_t'(NUM_REGS - 1 - a);
      #1;
      chk("reset_rd1", ReadData1, 32'd0);
      chk("reset_rd2", ReadData2, 32'd0);
    end

    cycle(1'b0, 1'b0, 5'd1, 32'd1, 5'd1, 5'd2);
    chk("read_only_rd1", ReadData1, 32'd0);
    chk("read_only_rd2", ReadData2, 32'd0);

    cycle(1'b0, 1'b1, 5'd1, 32'd2, 5'd1, 5'd2);
    chk("single_write", ReadData1, 32'd2);
    cycle(1'b0, 1'b0, 5'd2, 32'd3, 5'd1, 5'd2);
    chk("no_write_we0", ReadData2, 32'd0);

    cycle(1'b0, 1'b1, 5'd2, 32'd16, 5'd1, 5'd2);
    chk("overwrite_first", ReadData2, 32'd16);
    cycle(1'b0, 1'b1, 5'd2, 32'd3, 5'd1, 5'd2);
    chk("overwrite_last", ReadData2, 32'd3);
    chk("overwrite_other", ReadData1, 32'd2);

    cycle(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    chk("zero_reg", ReadData1, 32'd0);

    cycle(1'b0, 1'b1, 5'd5, 32'hA5A5_0001, 5'd5, 5'd5);
    chk("pre_reset_val", ReadData1, 32'hA5A5_0001);
    cycle(1'b1, 1'b1, 5'd5, 32'd7, 5'd5, 5'd1);
    chk("reset_priority", ReadData1, 32'd0);
    chk("reset_clears", ReadData2, 32'd0);

    @(posedge Clk);
    Reset = 1'b0; RegWre = 1'b1; WriteReg = 5'd3; WriteData = 32'd9; rs = 5'd3; rt = 5'd3;
    #1;
`ifdef RF_BYPASS_EN
    chk("bypass_rd1", ReadData1, 32'd9);
`else
    chk("no_bypass_rd1", ReadData1, 32'd0);
`endif
    @(negedge Clk);
    model[3] = 32'd9;
    #1;
    chk("write_visible", ReadData2, 32'd9);

    // Random traffic with occasional reset and aliased read ports.
    for (int n = 0; n < 400; n++) begin
      reg_addr_t a1, a2;
      a1 = reg_addr_t'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 7) == 0) ? a1 : reg_addr_t'($urandom_range(0, 31));
      cycle(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0),
            reg_addr_t'($urandom_range(0, 31)), word_t'($urandom), a1, a2);
      if (a1 == a2) chk("same_addr", ReadData1, ReadData2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

General-purpose register file for the pipelined MIPS-style CPU: 32 registers of 32 bits, two combinational read ports and one write port. It sits in the decode (ID) stage for operand reads (rs, rt) and is written by write-back (WB). Writes commit on the falling edge of Clk, so a value written in WB is readable by ID later in the same cycle.

## Interface
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register index width; register count = 2**ADDR_WIDTH (32)

Clock and reset: one clock, `Clk`; reset `Reset` is synchronous and active-high.

- Clk  input  1  clock; all state updates on its falling edge
- Reset  input  1  synchronous active-high reset, sampled on the falling edge of Clk
- RegWre  input  1  write enable
- rs  input  ADDR_WIDTH  read address, port 1
- rt  input  ADDR_WIDTH  read address, port 2
- WriteReg  input  ADDR_WIDTH  write address
- WriteData  input  DATA_WIDTH  write data
- ReadData1  output  DATA_WIDTH  contents of register rs
- ReadData2  output  DATA_WIDTH  contents of register rt

## Operation
- Storage: 32 x 32-bit registers. Register 0 is hard-wired to 0.
- Reads are purely combinational:
  - ReadData1 = reg[rs]; ReadData2 = reg[rt].
  - Address 0 always returns 0.
- Write: on the Clk falling edge with RegWre=1 and WriteReg≠0, reg[WriteReg] ← WriteData. Writes to register 0 are discarded.
- RegWre=0: no register changes, whatever WriteReg and WriteData hold.
- Reset: on the Clk falling edge with Reset=1, every register is cleared to 0. Reset overrides a simultaneous write.
- Same address on both read ports: both outputs return the same value.
- Rewriting a register: the last write wins; there is no accumulation.
- Undriven (X) addresses are not supported.

## Timing
- Read latency: zero cycles, combinational from rs, rt and the register array.
- Write latency: the new value is visible on the read ports right after the falling edge where it commits. It is therefore available to ID in the second half of the same cycle.
- Reset value of every register and every output: 0. Outputs read 0 immediately after the reset edge.
- Reset asserted during a write cycle: the write is lost and the register is 0.
- Power-up before the first reset: register contents are undefined, except register 0, which reads 0.

## Configuration
- RF_BYPASS_EN defined:
  - Write-through forwarding is enabled. While RegWre=1 and WriteReg≠0, ReadDataN = WriteData combinationally whenever the matching read address equals WriteReg, before the edge.
  - Reset=1 suppresses the bypass.
- RF_BYPASS_EN undefined:
  - Reads return array contents only. The new value appears only after the falling edge.

## Structure
- Shared package `rf_pkg` holds:
  - DATA_WIDTH and ADDR_WIDTH defaults
  - NUM_REGS = 32
  - ZERO_REG = 5'd0
  - typedefs `reg_addr_t` (logic [4:0]) and `word_t` (logic [31:0])
- One sub-module: `rf_read_port`, a combinational selector handling array lookup, the zero-register rule and the optional bypass. It is instantiated twice, once for rs and once for rt.

## Test plan
- Reset=1 for one falling edge → ReadData1 = ReadData2 = 0 for every rs and rt.
- Read-only check:
  - Stimulus: RegWre=0, WriteReg=1, WriteData=1, rs=1, rt=2, one clock.
  - Required: ReadData1=0 and ReadData2=0 after the edge.
- Single write:
  - Stimulus: RegWre=1, WriteReg=1, WriteData=2.
  - Required: ReadData1=2 after the falling edge.
  - Then RegWre=0, WriteReg=2, WriteData=3 → ReadData2 stays 0.
- Overwrite:
  - Stimulus: RegWre=1, WriteReg=2, WriteData=16, one edge.
  - Required: ReadData2=16.
  - Then WriteData=3, one edge → ReadData2=3, and ReadData1 stays 2.
- Zero register: RegWre=1, WriteReg=0, WriteData=32'hFFFFFFFF, then rs=0 → ReadData1=0.
- Reset priority: Reset=1 and RegWre=1 with WriteReg=5, WriteData=7 on the same edge → rs=5 reads 0.
- Bypass (RF_BYPASS_EN only): RegWre=1, WriteReg=3, WriteData=9, rs=3, before the edge → ReadData1=9.
